// File: rtl/riscv_wb_queue.sv
// Writeback queue: buffers LSU/multicycle results until register file port B is free,
// and flags decode-stage reads that would hit a still-queued destination register.
module riscv_wb_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [ADDR_WIDTH-1:0]         push_addr_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          drain_en_i,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          we_b_o,
  input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
  output logic                          pending_a_o,
  output logic                          pending_b_o,
  output logic                          pending_c_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PtrW-1:0]       r_wptr, r_rptr;
  logic [CntW-1:0]       r_count;

  logic w_pop, w_push_acc, w_enq, w_nonempty;
  logic w_pend_a, w_pend_b, w_pend_c;

  assign w_nonempty   = (r_count != '0);
  assign w_pop        = drain_en_i && w_nonempty;
  assign push_ready_o = (r_count < DepthC) || w_pop;
  assign w_push_acc   = push_valid_i && push_ready_o;
  // Writes to integer R0 are accepted so the producer can retire them, but never stored.
  assign w_enq        = w_push_acc && (push_addr_i != '0);

  assign we_b_o    = w_pop;
  assign waddr_b_o = w_nonempty ? r_addr[r_rptr] : '0;
  assign wdata_b_o = w_nonempty ? r_data[r_rptr] : '0;
  assign count_o   = r_count;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [PtrW-1:0] w_off;
    logic            w_live;
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    w_pend_c = 1'b0;
    w_off    = '0;
    w_live   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off  = PtrW'(i) - r_rptr;
      w_live = (CntW'(w_off) < r_count);
      if (w_live && (r_addr[i] == raddr_a_i)) w_pend_a = 1'b1;
      if (w_live && (r_addr[i] == raddr_b_i)) w_pend_b = 1'b1;
      if (w_live && (r_addr[i] == raddr_c_i)) w_pend_c = 1'b1;
    end
  end

  assign pending_a_o = w_pend_a && (raddr_a_i != '0);
  assign pending_b_o = w_pend_b && (raddr_b_i != '0);
  assign pending_c_o = w_pend_c && (raddr_c_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_wptr] <= push_addr_i;
        r_data[r_wptr] <= push_data_i;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CntW'(w_enq) - CntW'(w_pop);
    end
  end

endmodule

// File: tb/tb_riscv_wb_queue.sv
// Directed bench for riscv_wb_queue: inputs change on the falling edge, outputs are
// checked 1ns later, well away from the rising edge.
module tb_riscv_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [5:0]  push_addr_i;
  logic [31:0] push_data_i;
  logic        drain_en_i;
  logic [5:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        we_b_o;
  logic [5:0]  raddr_a_i, raddr_b_i, raddr_c_i;
  logic        pending_a_o, pending_b_o, pending_c_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  riscv_wb_queue #(.DEPTH(4), .ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_addr_i  (push_addr_i),
    .push_data_i  (push_data_i),
    .drain_en_i   (drain_en_i),
    .waddr_b_o    (waddr_b_o),
    .wdata_b_o    (wdata_b_o),
    .we_b_o       (we_b_o),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .raddr_c_i    (raddr_c_i),
    .pending_a_o  (pending_a_o),
    .pending_b_o  (pending_b_o),
    .pending_c_o  (pending_c_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Set inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d,
                       input logic drn);
    push_valid_i = v;
    push_addr_i  = a;
    push_data_i  = d;
    drain_en_i   = drn;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    drive(1'b0, 6'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_we", we_b_o, 0);
    check("rst_ready", push_ready_o, 1);
    check("rst_waddr", waddr_b_o, 0);
    check("rst_wdata", wdata_b_o, 0);
    rst_n = 1'b1;

    // Single push with drain enabled: no bypass, write the following cycle.
    drive(1'b1, 6'd5, 32'hDEADBEEF, 1'b1);
    check("p1_we_same_cycle", we_b_o, 0);
    check("p1_ready", push_ready_o, 1);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("p1_count", count_o, 1);
    check("p1_we", we_b_o, 1);
    check("p1_waddr", waddr_b_o, 5);
    check("p1_wdata", wdata_b_o, 32'hDEADBEEF);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("p1_count_after", count_o, 0);
    check("p1_we_after", we_b_o, 0);

    // Fill the queue, then push-and-pop while full.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 32'h100 + i, 1'b0);
      next_cycle();
    end
    drive(1'b0, 6'd0, 32'd0, 1'b0);
    raddr_a_i = 6'd4;
    #1;
    check("full_count", count_o, 4);
    check("full_ready", push_ready_o, 0);
    check("full_pending_tail", pending_a_o, 1);
    check("full_we_held", we_b_o, 0);
    next_cycle();
    check("hold_count", count_o, 4);
    drive(1'b1, 6'd5, 32'h105, 1'b1);
    check("full_pp_ready", push_ready_o, 1);
    check("full_pp_we", we_b_o, 1);
    check("full_pp_waddr", waddr_b_o, 1);
    check("full_pp_wdata", wdata_b_o, 32'h101);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("full_pp_count", count_o, 4);
    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, 6'd0, 32'd0, 1'b1);
      check($sformatf("order_addr%0d", i), waddr_b_o, i);
      check($sformatf("order_data%0d", i), wdata_b_o, 32'h100 + i);
      next_cycle();
    end
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("drained_count", count_o, 0);
    raddr_a_i = 6'd0;

    // R0 push is accepted but discarded.
    drive(1'b1, 6'd0, 32'h1234, 1'b1);
    check("r0_ready", push_ready_o, 1);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("r0_count", count_o, 0);
    check("r0_we", we_b_o, 0);
    next_cycle();
    check("r0_we_later", we_b_o, 0);

    // FP register 3 must not alias integer register 3.
    drive(1'b1, 6'h23, 32'h33, 1'b0);
    next_cycle();
    raddr_a_i = 6'h23; raddr_b_i = 6'h03; raddr_c_i = 6'h00;
    drive(1'b0, 6'd0, 32'd0, 1'b0);
    check("fp_pend_a", pending_a_o, 1);
    check("fp_pend_b", pending_b_o, 0);
    check("fp_pend_c_r0", pending_c_o, 0);
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("fp_pend_head", pending_a_o, 1);
    check("fp_waddr", waddr_b_o, 6'h23);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b0);
    check("fp_pend_a_after", pending_a_o, 0);
    check("fp_pend_b_after", pending_b_o, 0);
    raddr_a_i = '0; raddr_b_i = '0;

    // Same address twice; older value first. Pointers wrap (7 entries so far, then 9).
    drive(1'b1, 6'd7, 32'hA, 1'b0);
    next_cycle();
    drive(1'b1, 6'd7, 32'hB, 1'b0);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("dup_count", count_o, 2);
    check("dup1_addr", waddr_b_o, 7);
    check("dup1_data", wdata_b_o, 32'hA);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("dup2_we", we_b_o, 1);
    check("dup2_addr", waddr_b_o, 7);
    check("dup2_data", wdata_b_o, 32'hB);
    next_cycle();
    drive(1'b1, 6'd9, 32'h99, 1'b1);
    check("wrap_empty_we", we_b_o, 0);
    next_cycle();
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    check("wrap_addr", waddr_b_o, 9);
    check("wrap_data", wdata_b_o, 32'h99);
    next_cycle();

    // Asynchronous reset mid-operation discards queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(10 + i), 32'h200 + i, 1'b0);
      next_cycle();
    end
    drive(1'b0, 6'd0, 32'd0, 1'b0);
    check("pre_rst_count", count_o, 3);
    drive(1'b0, 6'd0, 32'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", count_o, 0);
    check("async_rst_we", we_b_o, 0);
    check("async_rst_waddr", waddr_b_o, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("rel_we", we_b_o, 0);
    next_cycle();
    #1;
    check("rel_we_next", we_b_o, 0);
    check("rel_count", count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
